// File: rtl/divider_if.sv
// Handshake and operand/result bundle between the pipeline control and the
// iterative divider.
interface divider_if #(
    parameter int DATA_W = 32
);
    logic              Start;
    logic              Signed;
    logic [DATA_W-1:0] Dividend;
    logic [DATA_W-1:0] Divisor;
    logic              Busy;
    logic              Done;
    logic [DATA_W-1:0] Quotient;
    logic [DATA_W-1:0] Remainder;
    logic              OF;

    modport master (
        output Start, Signed, Dividend, Divisor,
        input  Busy, Done, Quotient, Remainder, OF
    );

    modport slave (
        input  Start, Signed, Dividend, Divisor,
        output Busy, Done, Quotient, Remainder, OF
    );
endinterface

// File: rtl/divider.sv
// Iterative restoring divider (signed/unsigned), one quotient bit per clock,
// with single-cycle shortcuts for divide-by-zero and signed overflow.
module divider #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic     Clk,
    input  logic     Reset,
    divider_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [DATA_W-1:0] dvd_reg;      // dividend magnitude, becomes the quotient
    logic [DATA_W-1:0] dvs_reg;
    logic [DATA_W-1:0] rem_reg;
    logic              neg_q_reg, neg_r_reg;
    logic [DATA_W-1:0] quotient_reg, remainder_reg;
    logic              of_reg, done_reg;

    logic              div_zero, sgn_ovf, shortcut;
    logic              dvd_neg, dvs_neg;
    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   trial;
    logic              borrow;
    logic              q_bit;
    logic [DATA_W-1:0] rem_next;

    always_comb begin
        div_zero = (bus.Divisor == '0);
        sgn_ovf  = bus.Signed && (bus.Dividend == MIN_NEG) && (bus.Divisor == '1);
        shortcut = div_zero || sgn_ovf;
        dvd_neg  = bus.Signed && bus.Dividend[DATA_W-1];
        dvs_neg  = bus.Signed && bus.Divisor[DATA_W-1];

        shifted           = {rem_reg, dvd_reg[DATA_W-1]};
        {borrow, trial}   = {1'b0, shifted} - {2'b00, dvs_reg};
        // A non-negative trial is always below the divisor, so trial[DATA_W]
        // is zero whenever borrow is clear; folding it in changes nothing.
        q_bit    = ~(borrow | trial[DATA_W]);
        rem_next = q_bit ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];

        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.Start && !shortcut) state_next = CALC;
            CALC:    if (cnt_reg == CNT_W'(1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            dvd_reg       <= '0;
            dvs_reg       <= '0;
            rem_reg       <= '0;
            neg_q_reg     <= 1'b0;
            neg_r_reg     <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            of_reg        <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.Start) begin
                        if (div_zero) begin
                            quotient_reg  <= '1;
                            remainder_reg <= bus.Dividend;
                            of_reg        <= 1'b1;
                            done_reg      <= 1'b1;
                        end else if (sgn_ovf) begin
                            quotient_reg  <= MIN_NEG;
                            remainder_reg <= '0;
                            of_reg        <= 1'b1;
                            done_reg      <= 1'b1;
                        end else begin
                            dvd_reg   <= dvd_neg ? -bus.Dividend : bus.Dividend;
                            dvs_reg   <= dvs_neg ? -bus.Divisor : bus.Divisor;
                            rem_reg   <= '0;
                            cnt_reg   <= CNT_W'(DATA_W);
                            neg_q_reg <= dvd_neg ^ dvs_neg;
                            neg_r_reg <= dvd_neg;
                        end
                    end
                end
                CALC: begin
                    rem_reg <= rem_next;
                    dvd_reg <= {dvd_reg[DATA_W-2:0], q_bit};
                    cnt_reg <= cnt_reg - CNT_W'(1);
                end
                FIX: begin
                    // Truncating division: the remainder follows the dividend's sign.
                    quotient_reg  <= neg_q_reg ? -dvd_reg : dvd_reg;
                    remainder_reg <= neg_r_reg ? -rem_reg : rem_reg;
                    of_reg        <= 1'b0;
                    done_reg      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.Busy      = (state_reg != IDLE);
    assign bus.Done      = done_reg;
    assign bus.Quotient  = quotient_reg;
    assign bus.Remainder = remainder_reg;
    assign bus.OF        = of_reg;
endmodule
